// File: rtl/bcd_updown_counter_pkg.sv
// Shared types and constants for the BCD up/down counter and its digit cells.
package bcd_updown_counter_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Any non-decimal nibble is forced to 0 so the count never holds a non-BCD digit.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MIN : d;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// One decimal digit of the cascaded counter: load, step up/down with 9<->0 wrap.
module bcd_digit
  import bcd_updown_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       sel,
  input  logic       load,
  input  bcd_digit_t load_digit,
  output bcd_digit_t digit,
  output logic       at_max,
  output logic       at_min
);

  bcd_digit_t r_digit;

  // Load outranks stepping; the caller gates step with the lower-digit carry/borrow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digit <= BCD_MIN;
    end else if (load) begin
      r_digit <= bcd_sanitize(load_digit);
    end else if (step) begin
      if (sel) begin
        r_digit <= (r_digit == BCD_MAX) ? BCD_MIN : r_digit + 4'd1;
      end else begin
        r_digit <= (r_digit == BCD_MIN) ? BCD_MAX : r_digit - 4'd1;
      end
    end
  end

  assign digit  = r_digit;
  assign at_max = (r_digit == BCD_MAX);
  assign at_min = (r_digit == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// NUM_DIGITS-wide BCD up/down counter with enable, sanitised parallel load and terminal count.
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sel,
  input  logic                              en,
  input  logic                              load,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] load_value,
  output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] count,
  output logic                              tc
);

  logic [NUM_DIGITS-1:0] w_atMax;
  logic [NUM_DIGITS-1:0] w_atMin;
  logic [NUM_DIGITS:0]   w_upChain;
  logic [NUM_DIGITS:0]   w_dnChain;

  assign w_upChain[0] = 1'b1;
  assign w_dnChain[0] = 1'b1;

  // w_upChain[k]/w_dnChain[k]: every digit below k is at 9 / at 0.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic w_step;

    assign w_step = en & (sel ? w_upChain[k] : w_dnChain[k]);

    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .step       (w_step),
      .sel        (sel),
      .load       (load),
      .load_digit (load_value[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit      (count[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .at_max     (w_atMax[k]),
      .at_min     (w_atMin[k])
    );

    assign w_upChain[k+1] = w_upChain[k] & w_atMax[k];
    assign w_dnChain[k+1] = w_dnChain[k] & w_atMin[k];
  end

  assign tc = en & ~load & (sel ? w_upChain[NUM_DIGITS] : w_dnChain[NUM_DIGITS]);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed, table-driven bench for 1-digit and 2-digit instances of bcd_updown_counter.
module tb_bcd_updown_counter;

  typedef struct {
    bit         which2;
    logic       load;
    logic       en;
    logic       sel;
    logic [7:0] loadValue;
    logic [7:0] expCount;
    logic       expTc;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       sel;
  logic       en;
  logic       load;
  logic [3:0] loadValue1;
  logic [7:0] loadValue2;
  logic [3:0] count1;
  logic [7:0] count2;
  logic       tc1;
  logic       tc2;

  int compared;
  int mismatched;
  vec_t vecs[$];

  bcd_updown_counter #(.NUM_DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .sel(sel), .en(en), .load(load),
    .load_value(loadValue1), .count(count1), .tc(tc1)
  );

  bcd_updown_counter #(.NUM_DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .sel(sel), .en(en), .load(load),
    .load_value(loadValue2), .count(count2), .tc(tc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic addVec(input bit w2, input logic ld, input logic e, input logic s,
                        input logic [7:0] lv, input logic [7:0] ec, input logic et);
    vec_t v;
    v.which2 = w2; v.load = ld; v.en = e; v.sel = s;
    v.loadValue = lv; v.expCount = ec; v.expTc = et;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    load       = v.load;
    en         = v.en;
    sel        = v.sel;
    loadValue1 = v.loadValue[3:0];
    loadValue2 = v.loadValue;
    @(posedge clk);
    #1;
    if (v.which2) begin
      checkOutput($sformatf("vec%0d_count2", idx), count2, v.expCount);
      checkOutput($sformatf("vec%0d_tc2", idx), {7'd0, tc2}, {7'd0, v.expTc});
    end else begin
      checkOutput($sformatf("vec%0d_count1", idx), {4'd0, count1}, v.expCount);
      checkOutput($sformatf("vec%0d_tc1", idx), {7'd0, tc1}, {7'd0, v.expTc});
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b0; sel = 1'b1; en = 1'b0; load = 1'b0;
    loadValue1 = 4'd0; loadValue2 = 8'h00;

    // 1-digit: count up through the 9 -> 0 wrap.
    for (int i = 1; i <= 13; i++) begin
      automatic logic [7:0] c = 8'(i % 10);
      addVec(0, 0, 1, 1, 8'h00, c, c == 8'd9);
    end
    // Count down through the 0 -> 9 wrap.
    addVec(0, 0, 1, 0, 8'h00, 8'd2, 0);
    addVec(0, 0, 1, 0, 8'h00, 8'd1, 0);
    addVec(0, 0, 1, 0, 8'h00, 8'd0, 1);
    addVec(0, 0, 1, 0, 8'h00, 8'd9, 0);
    addVec(0, 0, 1, 0, 8'h00, 8'd8, 0);
    // Direction change with no dead cycle.
    addVec(0, 1, 1, 1, 8'h05, 8'd5, 0);
    addVec(0, 0, 1, 0, 8'h00, 8'd4, 0);
    addVec(0, 0, 1, 0, 8'h00, 8'd3, 0);
    addVec(0, 0, 1, 0, 8'h00, 8'd2, 0);
    addVec(0, 0, 1, 1, 8'h00, 8'd3, 0);
    addVec(0, 0, 1, 1, 8'h00, 8'd4, 0);
    // Hold with en=0, then loads.
    addVec(0, 1, 0, 1, 8'h07, 8'd7, 0);
    for (int i = 0; i < 5; i++) addVec(0, 0, 0, 1, 8'h00, 8'd7, 0);
    addVec(0, 1, 0, 1, 8'h04, 8'd4, 0);
    addVec(0, 1, 0, 1, 8'h0C, 8'd0, 0);
    addVec(0, 1, 1, 0, 8'h02, 8'd2, 0);
    addVec(0, 0, 1, 0, 8'h00, 8'd1, 0);
    addVec(0, 0, 1, 0, 8'h00, 8'd0, 1);
    addVec(0, 1, 1, 0, 8'h00, 8'd0, 0);
    // 2-digit cascade.
    addVec(1, 1, 1, 1, 8'h98, 8'h98, 0);
    addVec(1, 0, 1, 1, 8'h00, 8'h99, 1);
    addVec(1, 0, 1, 1, 8'h00, 8'h00, 0);
    addVec(1, 0, 1, 1, 8'h00, 8'h01, 0);
    addVec(1, 1, 1, 0, 8'h10, 8'h10, 0);
    addVec(1, 0, 1, 0, 8'h00, 8'h09, 0);
    addVec(1, 0, 1, 0, 8'h00, 8'h08, 0);
    addVec(1, 1, 1, 0, 8'h01, 8'h01, 0);
    addVec(1, 0, 1, 0, 8'h00, 8'h00, 1);
    addVec(1, 0, 1, 0, 8'h00, 8'h99, 0);
    addVec(1, 1, 0, 0, 8'hA5, 8'h05, 0);
    addVec(1, 1, 0, 0, 8'h3F, 8'h30, 0);
    addVec(1, 1, 0, 1, 8'h09, 8'h09, 0);
    addVec(1, 0, 1, 1, 8'h00, 8'h10, 0);
    addVec(0, 1, 0, 1, 8'h06, 8'd6, 0);

    // Reset holds both counters at 0.
    #1;
    checkOutput("reset_count1", {4'd0, count1}, 8'h00);
    checkOutput("reset_count2", count2, 8'h00);
    rst = 1'b1;
    #2;
    checkOutput("reset_release_count1", {4'd0, count1}, 8'h00);

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Asynchronous reset between edges at count=6.
    @(negedge clk);
    load = 1'b0; en = 1'b1; sel = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_count1", {4'd0, count1}, 8'h00);
    checkOutput("async_rst_count2", count2, 8'h00);
    checkOutput("async_rst_tc_up", {7'd0, tc1}, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_count1", {4'd0, count1}, 8'h00);
    sel = 1'b0;
    #1;
    checkOutput("rst_tc_down", {7'd0, tc1}, 8'h01);
    @(negedge clk);
    rst = 1'b1;
    sel = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_first_step", {4'd0, count1}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
